// File: rtl/digit_entry_ctrl_if.sv
// Key inputs and display outputs of the hex digit entry controller.
// The bench drives the keys through master; the controller is the slave.
interface digit_entry_ctrl_if;
  logic [15:0]     pb;
  logic            btn_adv;
  logic            btn_back;
  logic            btn_clr;
  logic [7:0][3:0] digits;
  logic [7:0]      flt_pt;
  logic [2:0]      cursor;
  logic [3:0]      count;
  logic            entry_strobe;
  logic [3:0]      entry_val;

  modport master (
    output pb, btn_adv, btn_back, btn_clr,
    input  digits, flt_pt, cursor, count,
    input  entry_strobe, entry_val
  );

  modport slave (
    input  pb, btn_adv, btn_back, btn_clr,
    output digits, flt_pt, cursor, count,
    output entry_strobe, entry_val
  );
endinterface

// File: rtl/digit_entry_ctrl.sv
// Debounced hex-key entry into an 8-digit display register with
// a wrapping cursor and a blinking decimal-point cursor marker.
module digit_entry_ctrl #(
  parameter int DEBOUNCE_CYC = 120000,
  parameter int BLINK_HALF   = 6000000
) (
  input logic          CLK,
  input logic          NRST,
  digit_entry_ctrl_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam int BW = $clog2(BLINK_HALF);

  typedef enum logic {IDLE, HELD} state_t;

  logic [18:0]     s1;
  logic [18:0]     s2;
  logic [18:0]     cand;
  logic [18:0]     deb;
  logic [DW-1:0]   dcnt;
  logic [BW-1:0]   bcnt;
  logic            blink;
  state_t          state;
  logic [7:0][3:0] dig;
  logic [2:0]      cur;
  logic [3:0]      cnt;
  logic            stb;
  logic [3:0]      val;

  logic [15:0]     hex;
  logic            idle;
  logic            hot1;
  logic [3:0]      key;
  logic            do_clr;
  logic            do_back;
  logic            do_adv;
  logic            do_wr;
  logic            act;

  assign hex  = deb[15:0];
  assign idle = (state == IDLE) && (deb != 19'd0);
  assign hot1 = (hex != 16'd0) &&
                ((hex & (hex - 16'd1)) == 16'd0);

  always_comb begin
    key = '0;
    for (int i = 0; i < 16; i++)
      if (hex[i]) key = 4'(i);
  end

  // Priority resolved here so the decoder below sees one-hot selects
  assign do_clr  = idle & deb[18];
  assign do_back = idle & ~deb[18] & deb[17];
  assign do_adv  = idle & ~deb[18] & ~deb[17] & deb[16];
  assign do_wr   = idle & ~(|deb[18:16]) & hot1;
  assign act     = do_clr | (do_back & (cnt != 4'd0))
                 | do_adv | do_wr;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      s1   <= '0;
      s2   <= '0;
      cand <= '0;
      deb  <= '0;
      dcnt <= '0;
    end else begin
      s1 <= {bus.btn_clr, bus.btn_back, bus.btn_adv, bus.pb};
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        dcnt <= '0;
      end else if (dcnt == DW'(DEBOUNCE_CYC - 1)) begin
        deb <= cand;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state <= IDLE;
      dig   <= '0;
      cur   <= '0;
      cnt   <= '0;
      stb   <= 1'b0;
      val   <= '0;
    end else begin
      stb <= 1'b0;
      unique case (state)
        IDLE: begin
          if (idle) begin
            state <= HELD;
            unique case (1'b1)
              do_clr: begin
                dig <= '0;
                cur <= '0;
                cnt <= '0;
              end
              do_back: begin
                if (cnt != 4'd0) begin
                  cur            <= cur - 3'd1;
                  dig[cur-3'd1]  <= 4'd0;
                  cnt            <= cnt - 4'd1;
                end
              end
              do_adv: begin
                cur <= cur + 3'd1;
              end
              do_wr: begin
                dig[cur] <= key;
                cur      <= cur + 3'd1;
                cnt      <= (cnt == 4'd8) ? 4'd8 : cnt + 4'd1;
                stb      <= 1'b1;
                val      <= key;
              end
              default: ;
            endcase
          end
        end
        HELD: begin
          if (deb == 19'd0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Any effective action restarts the blink phase so the cursor shows
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      bcnt  <= '0;
      blink <= 1'b1;
    end else if (act) begin
      bcnt  <= '0;
      blink <= 1'b1;
    end else if (bcnt == BW'(BLINK_HALF - 1)) begin
      bcnt  <= '0;
      blink <= ~blink;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end

  assign bus.digits       = dig;
  assign bus.cursor       = cur;
  assign bus.count        = cnt;
  assign bus.entry_strobe = stb;
  assign bus.entry_val    = val;
  assign bus.flt_pt       = blink ? (8'd1 << cur) : 8'd0;
endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Scoreboarded bench for digit_entry_ctrl: written values are queued
// at press time and matched against entry_strobe/entry_val.
module tb_digit_entry_ctrl;
  localparam int DEB = 4;
  localparam int BLK = 8;

  logic CLK  = 1'b0;
  logic NRST = 1'b0;

  digit_entry_ctrl_if bus ();

  digit_entry_ctrl #(
    .DEBOUNCE_CYC(DEB),
    .BLINK_HALF  (BLK)
  ) dut (
    .CLK (CLK),
    .NRST(NRST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] sb[$];
  logic [3:0] md[8];
  logic [2:0] mcur;
  logic [3:0] mcnt;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdig();
    logic [31:0] r;
    for (int i = 0; i < 8; i++) r[i*4 +: 4] = md[i];
    return r;
  endfunction

  always @(negedge CLK) begin
    if (NRST && bus.entry_strobe) begin
      if (sb.size() == 0)
        check("unexpected_strobe", 32'(bus.entry_strobe), 32'd0);
      else
        check("entry_val", 32'(bus.entry_val), 32'(sb.pop_front()));
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive(logic [18:0] v);
    {bus.btn_clr, bus.btn_back, bus.btn_adv, bus.pb} = v;
  endtask

  task automatic mreset();
    for (int i = 0; i < 8; i++) md[i] = 4'd0;
    mcur = 3'd0;
    mcnt = 4'd0;
  endtask

  task automatic mhex(int k);
    sb.push_back(4'(k));
    md[mcur] = 4'(k);
    mcur = mcur + 3'd1;
    if (mcnt < 4'd8) mcnt = mcnt + 4'd1;
  endtask

  task automatic press(logic [18:0] v);
    drive(v);
    tick(10);
    drive(19'd0);
    tick(12);
  endtask

  task automatic verify(string tag);
    check({tag, "_digits"}, bus.digits, mdig());
    check({tag, "_cursor"}, 32'(bus.cursor), 32'(mcur));
    check({tag, "_count"}, 32'(bus.count), 32'(mcnt));
  endtask

  task automatic hex(int k);
    mhex(k);
    press(19'd1 << k);
  endtask

  task automatic back();
    if (mcnt != 4'd0) begin
      mcur = mcur - 3'd1;
      md[mcur] = 4'd0;
      mcnt = mcnt - 4'd1;
    end
    press(19'd1 << 17);
  endtask

  task automatic check_reset(string tag);
    check({tag, "_digits"}, bus.digits, 32'd0);
    check({tag, "_cursor"}, 32'(bus.cursor), 32'd0);
    check({tag, "_count"}, 32'(bus.count), 32'd0);
    check({tag, "_strobe"}, 32'(bus.entry_strobe), 32'd0);
    check({tag, "_val"}, 32'(bus.entry_val), 32'd0);
    check({tag, "_flt"}, 32'(bus.flt_pt), 32'h01);
  endtask

  initial begin
    drive(19'd0);
    mreset();
    tick(3);
    check_reset("rst");
    NRST = 1'b1;
    tick(2);

    // exact latency of a single key, then blink phase
    mhex(3);
    drive(19'h00008);
    tick(7);
    check("pre_digits", bus.digits, 32'd0);
    check("pre_strobe", 32'(bus.entry_strobe), 32'd0);
    tick(1);
    verify("key3");
    check("key3_strobe", 32'(bus.entry_strobe), 32'd1);
    check("key3_flt_on", 32'(bus.flt_pt), 32'h02);
    tick(8);
    check("key3_flt_off", 32'(bus.flt_pt), 32'h00);
    tick(8);
    check("key3_flt_back", 32'(bus.flt_pt), 32'h02);
    drive(19'd0);
    tick(12);
    verify("key3_rel");

    // held key with short glitches on another key
    mhex(5);
    drive(19'd1 << 5);
    tick(10);
    for (int r = 0; r < 3; r++) begin
      drive((19'd1 << 5) | (19'd1 << 9));
      tick(2);
      drive(19'd1 << 5);
      tick(6);
    end
    drive(19'd0);
    tick(12);
    verify("glitch");

    mreset();
    press(19'd1 << 18);
    verify("clr0");
    hex(10);
    for (int k = 1; k <= 8; k++) hex(k);
    verify("wrap");
    check("wrap_d0", 32'(bus.digits[0]), 32'd8);
    check("wrap_d7", 32'(bus.digits[7]), 32'd7);

    mreset();
    press(19'd1 << 18);
    hex(1);
    hex(2);
    back();
    verify("back1");
    back();
    back();
    verify("back3");
    back();
    verify("back_empty");

    hex(7);
    mreset();
    press((19'd1 << 18) | (19'd1 << 4));
    verify("clr_pb");
    mcur = mcur + 3'd1;
    press(19'd1 << 16);
    verify("adv");

    // reset while a key is held mid-HELD
    mhex(2);
    drive(19'd1 << 2);
    tick(10);
    verify("held2");
    NRST = 1'b0;
    tick(1);
    check_reset("midrst");
    NRST = 1'b1;
    mreset();
    mhex(2);
    tick(10);
    verify("redeb");
    drive(19'd0);
    tick(12);

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
